vga_frame_ctrl: RTL and testbench
=================================

// Module: vga_frame_ctrl
// PURPOSE
//  Wishbone-slave configuration/status controller for the VGA core. Holds background colour,
//  sprite positions and enable; commits new settings only at vertical blank (no tearing).
//  Accumulates collision bits per frame, counts frames, raises an IRQ.
//  Sits between the Caravel Wishbone bus and the vga_core configuration inputs.
// PARAMETERS
//  NUM_SPRITES  2             number of sprite X/Y register pairs (1..8)
//  COORD_W      10            sprite coordinate width
//  COLOR_W      12            RGB colour width (4:4:4)
//  COLL_W       12            collision vector width
//  BASE_ADDR    32'h3000_0000 Wishbone base address; decode on adr[31:8]
// PORTS
//  clk            in   1                   system clock
//  rst_n          in   1                   asynchronous active-low reset
//  wbs_cyc_i      in   1                   Wishbone cycle
//  wbs_stb_i      in   1                   Wishbone strobe
//  wbs_we_i       in   1                   write enable
//  wbs_sel_i      in   4                   byte selects (honoured on writes)
//  wbs_adr_i      in   32                  byte address
//  wbs_dat_i      in   32                  write data
//  wbs_ack_o      out  1                   acknowledge
//  wbs_dat_o      out  32                  read data (valid with ack)
//  vblank_start_i in   1                   1-cycle pulse from timing gen at start of vertical blank
//  collision_i    in   COLL_W              collision flags of the frame just ended (stable on pulse)
//  cfg_enable_o   out  1                   VGA output enable
//  cfg_bg_color_o out  COLOR_W             active background colour
//  cfg_spr_x_o    out  NUM_SPRITES*COORD_W active sprite X, sprite i at [i*COORD_W +: COORD_W]
//  cfg_spr_y_o    out  NUM_SPRITES*COORD_W active sprite Y, same packing
//  irq_o          out  1                   level IRQ: irq_en & |coll_sticky
// BEHAVIOUR
//  Register map (offset from BASE_ADDR):
//   0x00 CTRL  b0 enable (immediate, unshadowed); b1 commit (W1 arms; reads pending); b2 irq_en
//   0x04 BG    [COLOR_W-1:0] shadow background colour
//   0x08 STAT  [COLL_W-1:0] sticky collisions (W1C); [31:16] frame count (RO)
//   0x10+8*i SPR_X[i], 0x14+8*i SPR_Y[i] shadow sprite coordinates
//   Unmapped offsets in the 256 B window: acked, read 0, writes dropped. Outside window: no ack.
//  Wishbone: ack asserted the cycle after cyc&stb&!ack, held exactly 1 cycle; write takes
//   effect on the ack cycle; back-to-back access max one every 2 cycles.
//  Unused register bits read 0.
//  Commit: on vblank_start_i with pending=1, shadow BG/SPR copied to active outputs and
//   pending cleared in the same cycle. pending=0: outputs unchanged.
//  Same-cycle write + vblank_start_i: commit uses pre-write shadow values; a CTRL commit write
//   in that cycle leaves pending=1 (applied next vblank).
//  Every vblank_start_i: coll_sticky |= collision_i; frame_cnt += 1 (16-bit, wraps 0xFFFF->0).
//  W1C to STAT same cycle as a set: set wins for that bit.
//  Reset (async, any time incl. mid-transfer): ack, dat_o, all shadow/active regs, pending,
//   irq_en, enable, sticky, frame_cnt -> 0; outputs therefore all 0.
// CONFIGURATION
//  VGA_FRAME_CTRL_SHADOW_EN defined: double-buffered behaviour above.
//  Not defined: BG/SPR writes update active outputs directly on the ack cycle; commit bit is
//   ignored and reads 0; vblank_start_i only affects collisions and frame count.
// TESTING
//  1 Reset: hold rst_n=0 -> all outputs 0; read CTRL/STAT -> 0x0000_0000.
//  2 Write BG=0xF00, SPR_X[0]=100, CTRL=0x3 -> cfg_bg_color_o stays 0 until vblank pulse,
//    then 0xF00, spr0 X=100; CTRL reads 0x1 after pulse. (Without SHADOW_EN: 0xF00 on ack.)
//  3 collision_i=0x332 on pulse, CTRL b2=1 -> STAT[11:0]=0x332, irq_o=1; write STAT=0x332 -> irq_o=0.
//  4 CTRL commit write coincident with vblank pulse -> pending still 1; applied at next pulse.
//  5 65536 vblank pulses -> STAT[31:16] wraps to 0; read of offset 0xFC acks, returns 0.
//  6 Assert rst_n=0 while ack pending -> ack drops immediately, no register modified.

Source files
------------

// File: rtl/vga_frame_ctrl.sv
// Wishbone config/status block for the VGA core: colour, sprites, collisions, IRQ.
// Define VGA_FRAME_CTRL_SHADOW_EN to double-buffer BG/SPR until vertical blank.
module vga_frame_ctrl #(
   parameter int          NUM_SPRITES = 2,
   parameter int          COORD_W     = 10,
   parameter int          COLOR_W     = 12,
   parameter int          COLL_W      = 12,
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           wbs_cyc_i,
   input  logic                           wbs_stb_i,
   input  logic                           wbs_we_i,
   input  logic [3:0]                     wbs_sel_i,
   input  logic [31:0]                    wbs_adr_i,
   input  logic [31:0]                    wbs_dat_i,
   output logic                           wbs_ack_o,
   output logic [31:0]                    wbs_dat_o,
   input  logic                           vblank_start_i,
   input  logic [COLL_W-1:0]              collision_i,
   output logic                           cfg_enable_o,
   output logic [COLOR_W-1:0]             cfg_bg_color_o,
   output logic [NUM_SPRITES*COORD_W-1:0] cfg_spr_x_o,
   output logic [NUM_SPRITES*COORD_W-1:0] cfg_spr_y_o,
   output logic                           irq_o
);

   typedef logic [NUM_SPRITES-1:0][COORD_W-1:0] spr_t;

   logic                   ack_q;
   logic [31:0]            dat_q;
   logic                   enable;
   logic                   irq_en;
   logic                   pending;
   logic [COLL_W-1:0]      sticky;
   logic [15:0]            frame_cnt;
   logic [COLOR_W-1:0]     act_bg;
   spr_t                   act_x;
   spr_t                   act_y;
   logic [COLOR_W-1:0]     rd_bg;
   spr_t                   rd_x;
   spr_t                   rd_y;

   logic                   hit;
   logic                   req;
   logic                   wr;
   logic                   aligned;
   logic [5:0]             widx;
   logic                   wr_ctrl;
   logic                   wr_bg;
   logic                   wr_stat;
   logic [NUM_SPRITES-1:0] wr_sx;
   logic [NUM_SPRITES-1:0] wr_sy;
   logic [31:0]            wmask;
   logic [31:0]            wdat;
   logic [COLL_W-1:0]      clr;
   logic [COLL_W-1:0]      set;
   logic [31:0]            rdata;

   assign hit     = wbs_cyc_i & wbs_stb_i &
                    (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign req     = hit & ~ack_q;
   assign wr      = req & wbs_we_i;
   assign aligned = (wbs_adr_i[1:0] == 2'b00);
   assign widx    = wbs_adr_i[7:2];
   assign wr_ctrl = wr & aligned & (widx == 6'd0);
   assign wr_bg   = wr & aligned & (widx == 6'd1);
   assign wr_stat = wr & aligned & (widx == 6'd2);

   assign wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                   {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
   assign wdat  = wbs_dat_i & wmask;

   function automatic logic [31:0] upd(input logic [31:0] old);
      return (old & ~wmask) | wdat;
   endfunction

   always_comb begin
      wr_sx = '0;
      wr_sy = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         wr_sx[i] = wr & aligned & (widx == 6'(4 + 2 * i));
         wr_sy[i] = wr & aligned & (widx == 6'(5 + 2 * i));
      end
   end

   // set-on-vblank wins over a same-cycle W1C
   assign clr = wr_stat ? wdat[COLL_W-1:0] : '0;
   assign set = vblank_start_i ? collision_i : '0;

`ifdef VGA_FRAME_CTRL_SHADOW_EN
   logic [COLOR_W-1:0] sh_bg;
   spr_t               sh_x;
   spr_t               sh_y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
         sh_bg   <= '0;
         sh_x    <= '0;
         sh_y    <= '0;
         act_bg  <= '0;
         act_x   <= '0;
         act_y   <= '0;
      end else begin
         // a commit request racing the pulse survives to the next one
         if (wr_ctrl & wbs_sel_i[0] & wbs_dat_i[1])
            pending <= 1'b1;
         else if (vblank_start_i)
            pending <= 1'b0;
         if (wr_bg)
            sh_bg <= COLOR_W'(upd(32'(sh_bg)));
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (wr_sx[i])
               sh_x[i] <= COORD_W'(upd(32'(sh_x[i])));
            if (wr_sy[i])
               sh_y[i] <= COORD_W'(upd(32'(sh_y[i])));
         end
         if (vblank_start_i & pending) begin
            act_bg <= sh_bg;
            act_x  <= sh_x;
            act_y  <= sh_y;
         end
      end
   end

   assign rd_bg = sh_bg;
   assign rd_x  = sh_x;
   assign rd_y  = sh_y;
`else
   assign pending = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_bg <= '0;
         act_x  <= '0;
         act_y  <= '0;
      end else begin
         if (wr_bg)
            act_bg <= COLOR_W'(upd(32'(act_bg)));
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (wr_sx[i])
               act_x[i] <= COORD_W'(upd(32'(act_x[i])));
            if (wr_sy[i])
               act_y[i] <= COORD_W'(upd(32'(act_y[i])));
         end
      end
   end

   assign rd_bg = act_bg;
   assign rd_x  = act_x;
   assign rd_y  = act_y;
`endif

   always_comb begin
      rdata = '0;
      if (aligned) begin
         case (widx)
            6'd0: rdata[2:0] = {irq_en, pending, enable};
            6'd1: rdata[COLOR_W-1:0] = rd_bg;
            6'd2: begin
               rdata[COLL_W-1:0] = sticky;
               rdata[31:16]      = frame_cnt;
            end
            default: begin
               for (int i = 0; i < NUM_SPRITES; i++) begin
                  if (widx == 6'(4 + 2 * i))
                     rdata[COORD_W-1:0] = rd_x[i];
                  if (widx == 6'(5 + 2 * i))
                     rdata[COORD_W-1:0] = rd_y[i];
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q     <= 1'b0;
         dat_q     <= '0;
         enable    <= 1'b0;
         irq_en    <= 1'b0;
         sticky    <= '0;
         frame_cnt <= '0;
      end else begin
         ack_q <= req;
         dat_q <= (req & ~wbs_we_i) ? rdata : 32'h0;
         if (wr_ctrl & wbs_sel_i[0]) begin
            enable <= wbs_dat_i[0];
            irq_en <= wbs_dat_i[2];
         end
         sticky    <= (sticky & ~clr) | set;
         frame_cnt <= frame_cnt + 16'(vblank_start_i);
      end
   end

   assign wbs_ack_o      = ack_q;
   assign wbs_dat_o      = dat_q;
   assign cfg_enable_o   = enable;
   assign cfg_bg_color_o = act_bg;
   assign cfg_spr_x_o    = act_x;
   assign cfg_spr_y_o    = act_y;
   assign irq_o          = irq_en & (|sticky);

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Directed bench for vga_frame_ctrl (default or VGA_FRAME_CTRL_SHADOW_EN build).
// Expected values are hand-derived from the register map.
module tb_vga_frame_ctrl;

   localparam logic [31:0] A_CTRL = 32'h3000_0000;
   localparam logic [31:0] A_BG   = 32'h3000_0004;
   localparam logic [31:0] A_STAT = 32'h3000_0008;
   localparam logic [31:0] A_SX0  = 32'h3000_0010;
   localparam logic [31:0] A_SY1  = 32'h3000_001C;
   localparam logic [31:0] A_HOLE = 32'h3000_00FC;
   localparam logic [31:0] A_MIS  = 32'h3000_0002;
   localparam logic [31:0] A_OUT  = 32'h3000_0100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_w;
   logic        ack;
   logic [31:0] dat_r;
   logic        vblank;
   logic [11:0] coll;
   logic        en_o;
   logic [11:0] bg_o;
   logic [19:0] sx_o, sy_o;
   logic        irq;

   int n_cmp = 0;
   int n_err = 0;

   vga_frame_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wbs_cyc_i      (cyc),
      .wbs_stb_i      (stb),
      .wbs_we_i       (we),
      .wbs_sel_i      (sel),
      .wbs_adr_i      (adr),
      .wbs_dat_i      (dat_w),
      .wbs_ack_o      (ack),
      .wbs_dat_o      (dat_r),
      .vblank_start_i (vblank),
      .collision_i    (coll),
      .cfg_enable_o   (en_o),
      .cfg_bg_color_o (bg_o),
      .cfg_spr_x_o    (sx_o),
      .cfg_spr_y_o    (sy_o),
      .irq_o          (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] q, output logic acked);
      cyc = 1'b1; stb = 1'b1; we = w;
      adr = a; dat_w = d; sel = s;
      acked = 1'b0;
      q = '0;
      for (int k = 0; k < 6 && !acked; k++) begin
         @(posedge clk); #1;
         if (ack) begin
            acked = 1'b1;
            q = dat_r;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input string tag, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s);
      logic [31:0] q;
      logic        k;
      xfer(1'b1, a, d, s, q, k);
      check({tag, " ack"}, 32'(k), 32'd1);
   endtask

   task automatic rd(input string tag, input logic [31:0] a,
                     input logic [31:0] exp);
      logic [31:0] q;
      logic        k;
      xfer(1'b0, a, 32'h0, 4'h0, q, k);
      check({tag, " ack"}, 32'(k), 32'd1);
      check(tag, q, exp);
   endtask

   task automatic pulse(input logic [11:0] c, input int n);
      vblank = 1'b1; coll = c;
      repeat (n) @(posedge clk);
      #1;
      vblank = 1'b0; coll = '0;
   endtask

   // bus write landing on the same edge as a vblank pulse
   task automatic wr_vb(input string tag, input logic [31:0] a,
                        input logic [31:0] d, input logic [11:0] c);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1;
      adr = a; dat_w = d; sel = 4'hF;
      vblank = 1'b1; coll = c;
      @(posedge clk); #1;
      vblank = 1'b0; coll = '0;
      check({tag, " ack"}, 32'(ack), 32'd1);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] q;
      logic        k;
      rst_n = 1'b0;
      cyc = 0; stb = 0; we = 0; sel = 0;
      adr = 0; dat_w = 0; vblank = 0; coll = 0;

      repeat (3) @(posedge clk);
      #1;
      check("rst ack", 32'(ack), 32'd0);
      check("rst dat", dat_r, 32'd0);
      check("rst en", 32'(en_o), 32'd0);
      check("rst bg", 32'(bg_o), 32'd0);
      check("rst sx", 32'(sx_o), 32'd0);
      check("rst sy", 32'(sy_o), 32'd0);
      check("rst irq", 32'(irq), 32'd0);
      rst_n = 1'b1;
      rd("rst ctrl", A_CTRL, 32'h0);
      rd("rst stat", A_STAT, 32'h0);

      wr("bg", A_BG, 32'h0000_0F00, 4'hF);
`ifdef VGA_FRAME_CTRL_SHADOW_EN
      check("bg held", 32'(bg_o), 32'h0);
`else
      check("bg direct", 32'(bg_o), 32'hF00);
`endif
      wr("sx0", A_SX0, 32'd100, 4'hF);
      wr("sy1", A_SY1, 32'h155, 4'hF);
      wr("ctrl", A_CTRL, 32'h3, 4'hF);
      check("en", 32'(en_o), 32'd1);
`ifdef VGA_FRAME_CTRL_SHADOW_EN
      rd("ctrl pend", A_CTRL, 32'h3);
      check("bg pre", 32'(bg_o), 32'h0);
`endif
      pulse(12'h0, 1);
      check("bg com", 32'(bg_o), 32'hF00);
      check("sx com", 32'(sx_o), 32'd100);
      check("sy com", 32'(sy_o), 32'h5_5400);
      rd("ctrl post", A_CTRL, 32'h1);

      wr("bg b0", A_BG, 32'hFFFF_FFFF, 4'b0001);
      rd("bg b0", A_BG, 32'hFFF);
      wr("bg b1", A_BG, 32'h0000_0000, 4'b0010);
      rd("bg b1", A_BG, 32'h0FF);
`ifdef VGA_FRAME_CTRL_SHADOW_EN
      check("bg act", 32'(bg_o), 32'hF00);
`else
      check("bg act", 32'(bg_o), 32'h0FF);
`endif

      wr("ctrl irq", A_CTRL, 32'h5, 4'hF);
      pulse(12'h332, 1);
      rd("stat coll", A_STAT, 32'h0002_0332);
      check("irq set", 32'(irq), 32'd1);
      wr("w1c", A_STAT, 32'h332, 4'hF);
      check("irq clr", 32'(irq), 32'd0);
      rd("stat clr", A_STAT, 32'h0002_0000);

      pulse(12'h001, 1);
      wr_vb("setwin", A_STAT, 32'h1, 12'h001);
      rd("stat win", A_STAT, 32'h0004_0001);
      check("irq win", 32'(irq), 32'd1);
      wr("w1c2", A_STAT, 32'h1, 4'hF);
      check("irq clr2", 32'(irq), 32'd0);

      wr("bg a5", A_BG, 32'h0A5, 4'hF);
      wr_vb("race", A_CTRL, 32'h7, 12'h0);
`ifdef VGA_FRAME_CTRL_SHADOW_EN
      rd("race pend", A_CTRL, 32'h7);
      check("race bg", 32'(bg_o), 32'hF00);
`else
      rd("race pend", A_CTRL, 32'h5);
      check("race bg", 32'(bg_o), 32'h0A5);
`endif
      pulse(12'h0, 1);
      rd("late ctrl", A_CTRL, 32'h5);
      check("late bg", 32'(bg_o), 32'h0A5);
      rd("stat six", A_STAT, 32'h0006_0000);

      pulse(12'h0, 65529);
      rd("fc max", A_STAT, 32'hFFFF_0000);
      pulse(12'h0, 1);
      rd("fc wrap", A_STAT, 32'h0000_0000);

      rd("hole", A_HOLE, 32'h0);
      rd("misal", A_MIS, 32'h0);
      wr("hole w", A_HOLE, 32'hFFFF_FFFF, 4'hF);
      rd("hole ctrl", A_CTRL, 32'h5);
      xfer(1'b0, A_OUT, 32'h0, 4'h0, q, k);
      check("out ack", 32'(k), 32'd0);

      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1;
      adr = A_BG; dat_w = 32'h123; sel = 4'hF;
      @(posedge clk); #1;
      check("mid ack", 32'(ack), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async ack", 32'(ack), 32'd0);
      check("async bg", 32'(bg_o), 32'd0);
      check("async en", 32'(en_o), 32'd0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1;
      adr = A_BG; dat_w = 32'h123; sel = 4'hF;
      #3;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("pre ack", 32'(ack), 32'd0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      rd("pre bg", A_BG, 32'h0);
      rd("pre stat", A_STAT, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
